// File: rtl/adxl362_pkg.sv
// Shared constants and state type for the ADXL362 SPI register-access master.
package adxl362_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] CMD_FIFO_READ = 8'h0D;

  localparam logic [5:0] LAST_HALF = 6'd47;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CS_GAP
  } state_t;

endpackage

// File: rtl/adxl362_spi_master_clkgen.sv
// Half-period tick generator: pulses once every CLK_DIV clk cycles while enabled,
// and restarts from zero whenever it is disabled.
module adxl362_spi_master_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/adxl362_spi_master.sv
// SPI mode-0 master issuing 24-bit ADXL362 register read/write frames
// (command, address, data), with chip-select setup, hold and deselect gap.
module adxl362_spi_master
  import adxl362_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] address,
  input  logic [7:0] data_write,
  output logic [7:0] data_read,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       nCS
);

  state_t      state, next_state;
  logic        tick, rise, fall;
  logic [5:0]  half;
  logic [23:0] tx;
  logic [23:0] frame;
  logic [7:0]  rx;
  logic        rw_q;

  adxl362_spi_master_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .enable (state != IDLE),
    .tick   (tick)
  );

  assign frame = {(rw ? CMD_READ : CMD_WRITE), address, (rw ? 8'h00 : data_write)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // SCLK is high during even-numbered SHIFT half-periods; rise/fall mark its edges.
  always_comb begin
    next_state = state;
    rise       = 1'b0;
    fall       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = CS_SETUP;
      end
      CS_SETUP: begin
        if (tick) begin
          next_state = SHIFT;
          rise       = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!half[0]) begin
            fall = 1'b1;
          end else if (half == LAST_HALF) begin
            next_state = CS_HOLD;
          end else begin
            rise = 1'b1;
          end
        end
      end
      CS_HOLD: begin
        if (tick) next_state = CS_GAP;
      end
      CS_GAP: begin
        if (tick) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // All pin-facing outputs are registered from the upcoming state to stay glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      nCS       <= 1'b1;
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_read <= 8'h00;
      tx        <= '0;
      rx        <= '0;
      rw_q      <= 1'b0;
      half      <= '0;
    end else begin
      nCS  <= (next_state == IDLE) || (next_state == CS_GAP);
      busy <= (next_state != IDLE);
      done <= (state == CS_GAP) && (next_state == IDLE);

      if (rise) begin
        SCLK <= 1'b1;
      end else if (fall) begin
        SCLK <= 1'b0;
      end

      if (state == IDLE && start) begin
        rw_q <= rw;
        MOSI <= frame[23];
        tx   <= {frame[22:0], 1'b0};
        half <= '0;
      end else if (fall) begin
        MOSI <= tx[23];
        tx   <= {tx[22:0], 1'b0};
      end

      if (state == SHIFT && tick) begin
        half <= half + 6'd1;
      end

      if (rise) begin
        rx <= {rx[6:0], MISO};
      end

      if (state == CS_GAP && tick && rw_q) begin
        data_read <= rx;
      end
    end
  end

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Self-checking bench: ADXL362 responder model plus a scoreboard of expected
// MOSI bytes and data_read values, with a CLK_DIV=4 main DUT and 2/255 timing DUTs.
module tb_adxl362_spi_master;
  import adxl362_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [7:0] address, data_write, data_read;
  logic       busy, done, sclk, mosi, ncs;
  logic       miso = 1'b0;

  logic       start2, start255;
  logic       busy2, busy255, done2, done255, sclk2, sclk255, mosi2, mosi255, ncs2, ncs255;
  logic [7:0] rd2, rd255;

  always #5 clk = ~clk;

  adxl362_spi_master #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .address(address),
    .data_write(data_write), .data_read(data_read), .busy(busy), .done(done),
    .SCLK(sclk), .MOSI(mosi), .MISO(miso), .nCS(ncs)
  );

  adxl362_spi_master #(.CLK_DIV(2)) dut_div2 (
    .clk(clk), .rst(rst), .start(start2), .rw(1'b0), .address(8'h2D),
    .data_write(8'h02), .data_read(rd2), .busy(busy2), .done(done2),
    .SCLK(sclk2), .MOSI(mosi2), .MISO(1'b0), .nCS(ncs2)
  );

  adxl362_spi_master #(.CLK_DIV(255)) dut_div255 (
    .clk(clk), .rst(rst), .start(start255), .rw(1'b0), .address(8'h2C),
    .data_write(8'h93), .data_read(rd255), .busy(busy255), .done(done255),
    .SCLK(sclk255), .MOSI(mosi255), .MISO(1'b0), .nCS(ncs255)
  );

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard queues and the responder's register file.
  logic [7:0] exp_mosi[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_last = 8'h00;
  logic [7:0] mem [256];
  bit         aborting = 1'b1;

  int          bits = 0;
  logic [23:0] rx_sh = '0;
  logic [7:0]  out_byte = '0;
  bit          out_en = 1'b0;

  always @(negedge ncs) begin
    bits   = 0;
    rx_sh  = '0;
    out_en = 1'b0;
  end

  always @(posedge sclk) begin
    if (!ncs) begin
      rx_sh = {rx_sh[22:0], mosi};
      bits++;
      if (bits == 16 && rx_sh[15:8] == CMD_READ) begin
        out_byte = mem[rx_sh[7:0]];
        out_en   = 1'b1;
      end
    end
  end

  always @(negedge sclk) begin
    if (!ncs && out_en) begin
      miso     = out_byte[7];
      out_byte = {out_byte[6:0], 1'b0};
    end
  end

  // Frame end: compare captured MOSI bytes against the scoreboard, apply writes.
  always @(posedge ncs) begin
    logic [7:0] e;
    miso   = 1'b0;
    out_en = 1'b0;
    if (!aborting) begin
      checkOutput("sclk_rises", bits, 24);
      if (exp_mosi.size() < 3) begin
        checkOutput("mosi_queue_depth", exp_mosi.size(), 3);
      end else begin
        for (int i = 0; i < 3; i++) begin
          e = exp_mosi.pop_front();
          checkOutput($sformatf("mosi_byte%0d", i), rx_sh[23-8*i -: 8], e);
        end
      end
      if (bits == 24 && rx_sh[23:16] == CMD_WRITE) mem[rx_sh[15:8]] = rx_sh[7:0];
    end
  end

  // Main-DUT monitor: data_read scoreboard on done, invariants, chip-select gap.
  logic done_prev = 1'b0, ncs_prev = 1'b1;
  int   done_count = 0, ncs_falls = 0;
  int   viol_sclk = 0, viol_done = 0, viol_busy = 0;
  int   hi_run = 0, busy_run = 0, last_gap_total = 0, last_gap_busy = 0;

  always @(negedge clk) begin
    if (ncs === 1'b1 && sclk === 1'b1) viol_sclk++;
    if (done === 1'b1 && done_prev === 1'b1) viol_done++;
    if (busy === 1'b0 && ncs === 1'b0) viol_busy++;
    if (done === 1'b1) begin
      done_count++;
      if (exp_rd.size() == 0) checkOutput("data_read_queue", 0, 1);
      else checkOutput("data_read", data_read, exp_rd.pop_front());
    end
    if (ncs_prev === 1'b1 && ncs === 1'b0) begin
      ncs_falls++;
      last_gap_total = hi_run;
      last_gap_busy  = busy_run;
      hi_run   = 0;
      busy_run = 0;
    end
    if (ncs === 1'b1) begin
      hi_run++;
      if (busy === 1'b1) busy_run++;
    end
    done_prev = done;
    ncs_prev  = ncs;
  end

  // Timing monitor for the CLK_DIV=2 (index 0) and 255 (index 1) instances.
  logic [1:0] sclk_x, mosi_x, ncs_x;
  logic [1:0] sp = 2'b00, mp = 2'b00, np = 2'b11;
  int run[2], halves[2], bad_half[2], mosi_bad[2];
  int divs[2] = '{2, 255};
  int viol_sclk_x = 0;

  assign sclk_x = {sclk255, sclk2};
  assign mosi_x = {mosi255, mosi2};
  assign ncs_x  = {ncs255, ncs2};

  initial begin
    for (int k = 0; k < 2; k++) begin
      run[k] = 0; halves[k] = 0; bad_half[k] = 0; mosi_bad[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ncs_x[k] === 1'b1 && sclk_x[k] === 1'b1) viol_sclk_x++;
      if (ncs_x[k] === 1'b0) begin
        if (np[k] === 1'b1) begin
          run[k] = 1;
        end else if (sclk_x[k] !== sp[k]) begin
          halves[k]++;
          if (run[k] != divs[k]) bad_half[k]++;
          if (sclk_x[k] === 1'b1 && mosi_x[k] !== mp[k]) mosi_bad[k]++;
          run[k] = 1;
        end else begin
          run[k]++;
        end
      end
      sp[k] = sclk_x[k];
      mp[k] = mosi_x[k];
      np[k] = ncs_x[k];
    end
  end

  task automatic pushExp(input logic r, input logic [7:0] a, input logic [7:0] d);
    exp_mosi.push_back(r ? CMD_READ : CMD_WRITE);
    exp_mosi.push_back(a);
    exp_mosi.push_back(r ? 8'h00 : d);
    if (r) exp_last = mem[a];
    exp_rd.push_back(exp_last);
  endtask

  // Called at a negedge; returns the cycle index (start sampled = cycle 0) of done.
  task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [7:0] d, output int done_at);
    int n;
    pushExp(r, a, d);
    rw = r; address = a; data_write = d; start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      n++;
    end while (done !== 1'b1 && n < 2000);
    if (done === 1'b1) begin
      done_at = n;
      checkOutput("busy_at_done", busy, 0);
    end else begin
      done_at = -1;
      checkOutput("done_timeout", 0, 1);
    end
  endtask

  int done_at, n, f0, d0, done_at2, done_at255;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hAD;
    rst = 1'b1; start = 1'b0; rw = 1'b0; address = 8'h00; data_write = 8'h00;
    start2 = 1'b0; start255 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ncs", ncs, 1);
    checkOutput("reset_sclk", sclk, 0);
    checkOutput("reset_mosi", mosi, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_data_read", data_read, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    aborting = 1'b0;

    applyStimulus(1'b0, 8'h1F, 8'h52, done_at);
    checkOutput("write_done_cycle", done_at, 205);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 8'h00, 8'hFF, done_at);
    checkOutput("read_done_cycle", done_at, 205);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 8'h1F, 8'h00, done_at);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 8'h2D, 8'h02, done_at);
    checkOutput("write_keeps_data_read", data_read, 8'h52);
    repeat (2) @(negedge clk);

    // start held through most of a frame, then a fresh start in the done cycle.
    f0 = ncs_falls;
    pushExp(1'b1, 8'h00, 8'h00);
    rw = 1'b1; address = 8'h00; start = 1'b1;
    repeat (150) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("held_start_frames", ncs_falls - f0, 1);
    pushExp(1'b0, 8'h20, 8'hA5);
    rw = 1'b0; address = 8'h20; data_write = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("back_to_back_frames", ncs_falls - f0, 2);
    checkOutput("gap_ncs_high_while_busy", last_gap_busy, 4);
    checkOutput("gap_ncs_high_incl_done_cycle", last_gap_total, 5);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("back_to_back_done", done, 1);
    repeat (2) @(negedge clk);

    // Abort a read with rst during cycle 100.
    rw = 1'b1; address = 8'h00; start = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    checkOutput("abort_ncs_low_before", ncs, 0);
    aborting = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_ncs", ncs, 1);
    checkOutput("abort_sclk", sclk, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_data_read", data_read, 8'h00);
    d0 = done_count;
    repeat (300) @(negedge clk);
    checkOutput("abort_no_done", done_count - d0, 0);
    exp_mosi.delete();
    exp_rd.delete();
    exp_last = 8'h00;
    aborting = 1'b0;
    applyStimulus(1'b1, 8'h00, 8'h00, done_at);
    checkOutput("read_after_abort_done_cycle", done_at, 205);
    repeat (2) @(negedge clk);

    // Extreme dividers.
    start2 = 1'b1; start255 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; start255 = 1'b0;
    n = 1; done_at2 = -1; done_at255 = -1;
    while ((done_at2 < 0 || done_at255 < 0) && n < 20000) begin
      if (done2 === 1'b1 && done_at2 < 0) done_at2 = n;
      if (done255 === 1'b1 && done_at255 < 0) done_at255 = n;
      @(negedge clk);
      n++;
    end
    checkOutput("div2_done_cycle", done_at2, 103);
    checkOutput("div255_done_cycle", done_at255, 13006);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("div%0d_sclk_edges", divs[k]), halves[k], 48);
      checkOutput($sformatf("div%0d_half_period", divs[k]), bad_half[k], 0);
      checkOutput($sformatf("div%0d_mosi_stable", divs[k]), mosi_bad[k], 0);
    end
    checkOutput("div2_data_read", rd2, 8'h00);
    checkOutput("div255_data_read", rd255, 8'h00);
    checkOutput("div_busy_idle", {busy2, busy255}, 0);

    checkOutput("scoreboard_rd_empty", exp_rd.size(), 0);
    checkOutput("scoreboard_mosi_empty", exp_mosi.size(), 0);
    checkOutput("inv_sclk_low_when_deselected", viol_sclk + viol_sclk_x, 0);
    checkOutput("inv_done_one_cycle", viol_done, 0);
    checkOutput("inv_idle_implies_deselected", viol_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
